// File: rtl/text_console_writer.sv
// ---------------------------------------------------------------------------
// text_console_writer
//
// Turns a byte stream into writes for the 32x32 text buffer read by the tile
// layer. Keeps a cursor (col, line) plus a top_row that scrolls the visible
// window through the circular buffer, clears each row as the cursor enters
// it, and publishes the scroll position as a pixel offset.
//
// Parameters:
//   VISIBLE_ROWS  text rows shown on screen (1..31)
//   SPACE_CHAR    tile index written when clearing cells
//
// Ports:
//   i_pix_clk     pixel clock, all logic on its rising edge
//   i_reset       asynchronous active-high reset
//   i_char        input byte, sampled only on the accepting edge
//   i_char_valid  i_char is valid this cycle
//   o_char_ready  block accepts i_char this cycle (high only in IDLE)
//   o_wr_en       text buffer write strobe (registered)
//   o_wr_addr     {buf_row[4:0], col[4:0]} (registered, holds when idle)
//   o_wr_data     byte to write (registered, holds when idle)
//   o_offset_y    {8'b0, top_row, 3'b000}, scroll offset in pixels
// ---------------------------------------------------------------------------
module text_console_writer #(
  parameter int         VISIBLE_ROWS = 24,
  parameter logic [7:0] SPACE_CHAR   = 8'h00
) (
  input  logic        i_pix_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_char,
  input  logic        i_char_valid,
  output logic        o_char_ready,
  output logic        o_wr_en,
  output logic [9:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic [15:0] o_offset_y
);

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    PUT       = 2'd2,
    CLEAR_ROW = 2'd3
  } state_t;

  localparam logic [4:0]  LAST_LINE  = 5'(VISIBLE_ROWS - 1);
  localparam logic [4:0]  LAST_COL   = 5'd31;
  localparam logic [10:0] ALL_CELLS  = 11'd1024;
  localparam logic [10:0] ROW_CELLS  = 11'd32;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Registered state
  state_t      state_r;
  logic [10:0] cnt_r;       // number of clear writes already issued
  logic [4:0]  col_r;
  logic [4:0]  line_r;
  logic [4:0]  top_row_r;
  logic        put_bs_r;    // the pending PUT came from a backspace
  logic        wr_en_r;
  logic [9:0]  wr_addr_r;
  logic [7:0]  wr_data_r;

  // Next-state values
  state_t      state_s;
  logic [10:0] cnt_s;
  logic [4:0]  col_s;
  logic [4:0]  line_s;
  logic [4:0]  top_row_s;
  logic        put_bs_s;
  logic        wr_en_s;
  logic [9:0]  wr_addr_s;
  logic [7:0]  wr_data_s;

  // Helpers
  logic        accept_s;
  logic [4:0]  buf_row_s;
  logic [4:0]  adv_line_s;
  logic [4:0]  adv_top_s;
  logic [4:0]  adv_buf_row_s;

  assign accept_s  = (state_r == IDLE) && i_char_valid;
  assign buf_row_s = top_row_r + line_r;   // 5-bit add wraps mod 32

  // Cursor position after a line advance: move down, or scroll once the
  // bottom visible line is reached.
  always_comb begin
    adv_line_s = line_r;
    adv_top_s  = top_row_r;
    if (line_r < LAST_LINE) begin
      adv_line_s = line_r + 5'd1;
      adv_top_s  = top_row_r;
    end else begin
      adv_line_s = line_r;
      adv_top_s  = top_row_r + 5'd1;
    end
  end

  assign adv_buf_row_s = adv_top_s + adv_line_s;

  // Next-state and next-write decode. The write registers are loaded on the
  // same edge that enters a writing state, so a write is on the outputs for
  // exactly the cycles the FSM spends in PUT / CLEAR_ROW / CLEAR_ALL.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    col_s     = col_r;
    line_s    = line_r;
    top_row_s = top_row_r;
    put_bs_s  = put_bs_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;

    case (state_r)
      CLEAR_ALL: begin
        if (cnt_r == ALL_CELLS) begin
          state_s = IDLE;
          cnt_s   = 11'd0;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = cnt_r[9:0];
          wr_data_s = SPACE_CHAR;
          cnt_s     = cnt_r + 11'd1;
        end
      end

      IDLE: begin
        if (accept_s) begin
          case (i_char)
            CH_LF: begin
              col_s     = 5'd0;
              line_s    = adv_line_s;
              top_row_s = adv_top_s;
              state_s   = CLEAR_ROW;
              wr_en_s   = 1'b1;
              wr_addr_s = {adv_buf_row_s, 5'd0};
              wr_data_s = SPACE_CHAR;
              cnt_s     = 11'd1;
            end
            CH_CR: begin
              col_s = 5'd0;
            end
            CH_BS: begin
              if (col_r != 5'd0) begin
                col_s     = col_r - 5'd1;
                put_bs_s  = 1'b1;
                state_s   = PUT;
                wr_en_s   = 1'b1;
                wr_addr_s = {buf_row_s, col_r - 5'd1};
                wr_data_s = SPACE_CHAR;
              end else begin
                col_s = col_r;
              end
            end
            CH_FF: begin
              // Cursor and scroll reset on entry; address 0 goes out now.
              col_s     = 5'd0;
              line_s    = 5'd0;
              top_row_s = 5'd0;
              state_s   = CLEAR_ALL;
              wr_en_s   = 1'b1;
              wr_addr_s = 10'd0;
              wr_data_s = SPACE_CHAR;
              cnt_s     = 11'd1;
            end
            default: begin
              put_bs_s  = 1'b0;
              state_s   = PUT;
              wr_en_s   = 1'b1;
              wr_addr_s = {buf_row_s, col_r};
              wr_data_s = i_char;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end

      PUT: begin
        if (put_bs_r) begin
          state_s = IDLE;
        end else if (col_r == LAST_COL) begin
          // Wrap: move to the next line and start clearing it immediately.
          col_s     = 5'd0;
          line_s    = adv_line_s;
          top_row_s = adv_top_s;
          state_s   = CLEAR_ROW;
          wr_en_s   = 1'b1;
          wr_addr_s = {adv_buf_row_s, 5'd0};
          wr_data_s = SPACE_CHAR;
          cnt_s     = 11'd1;
        end else begin
          col_s   = col_r + 5'd1;
          state_s = IDLE;
        end
      end

      CLEAR_ROW: begin
        // line/top_row already point at the row being cleared
        if (cnt_r == ROW_CELLS) begin
          state_s = IDLE;
          cnt_s   = 11'd0;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = {buf_row_s, cnt_r[4:0]};
          wr_data_s = SPACE_CHAR;
          cnt_s     = cnt_r + 11'd1;
        end
      end

      default: begin
        state_s = CLEAR_ALL;
        cnt_s   = 11'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= CLEAR_ALL;
      cnt_r     <= 11'd0;
      col_r     <= 5'd0;
      line_r    <= 5'd0;
      top_row_r <= 5'd0;
      put_bs_r  <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 10'd0;
      wr_data_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      col_r     <= col_s;
      line_r    <= line_s;
      top_row_r <= top_row_s;
      put_bs_r  <= put_bs_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
    end
  end

  assign o_char_ready = (state_r == IDLE);
  assign o_wr_en      = wr_en_r;
  assign o_wr_addr    = wr_addr_r;
  assign o_wr_data    = wr_data_r;
  assign o_offset_y   = {8'b0, top_row_r, 3'b000};

endmodule
